// File: rtl/branch_resolve_tracker_pkg.sv
// Shared types for the branch resolve tracker: tracked-entry layout, FSM states, defaults.
package branch_pkg;

    localparam int BRT_DEFAULT_DEPTH = 8;
    localparam int BRT_PC_W          = 16;

    typedef struct packed {
        logic [BRT_PC_W-1:0] pc;
        logic                pred;
    } brt_entry_t;

    typedef enum logic [0:0] {
        BRT_RUN   = 1'b0,
        BRT_FLUSH = 1'b1
    } brt_state_t;

    function automatic logic brt_is_mispredict(input brt_entry_t entry, input logic taken);
        return (entry.pred != taken);
    endfunction

endpackage

// File: rtl/branch_resolve_tracker_if.sv
// Issue / resolve / training bundle between fetch-predict, execute and the tracker.
interface branch_resolve_tracker_if #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             issue_valid;
    logic             issue_ready;
    logic [PC_W-1:0]  issue_pc;
    logic             issue_pred;
    logic             exec_valid;
    logic             exec_ready;
    logic             exec_taken;
    logic             result_valid;
    logic [PC_W-1:0]  result_pc;
    logic             result;
    logic             mispredict;
    logic             flush;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output issue_valid, issue_pc, issue_pred, exec_valid, exec_taken,
        input  issue_ready, exec_ready, result_valid, result_pc, result,
               mispredict, flush, occupancy
    );

    modport slave (
        input  issue_valid, issue_pc, issue_pred, exec_valid, exec_taken,
        output issue_ready, exec_ready, result_valid, result_pc, result,
               mispredict, flush, occupancy
    );

endinterface

// File: rtl/branch_resolve_tracker_tag_fifo.sv
// In-order storage of predicted branches: memory, wrapping pointers, occupancy and a
// synchronous clear that wins over any push/pop in the same cycle.
module branch_tag_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = BRT_DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  brt_entry_t       entry_i,
    input  logic             pop_i,
    output brt_entry_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [OCC_W-1:0] occupancy_o
);

    brt_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // entry storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // next pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign full_o      = (occ_q == OCC_W'(DEPTH));
    assign empty_o     = (occ_q == OCC_W'(0));
    assign occupancy_o = occ_q;

endmodule

// File: rtl/branch_resolve_tracker.sv
// Tracks predicted branches in program order, pairs in-order resolutions with them to train
// the predictor, and flushes on mispredict. Optional perf counters: BRT_PERF_COUNTERS_EN.
module branch_resolve_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH        = BRT_DEFAULT_DEPTH,
    parameter int PC_W         = BRT_PC_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef BRT_PERF_COUNTERS_EN
    branch_resolve_tracker_if.slave   bus_if,
    output logic [31:0]               branch_count,
    output logic [31:0]               mispred_count
`else
    branch_resolve_tracker_if.slave   bus_if
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

    brt_state_t       state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             result_valid_q;
    logic [PC_W-1:0]  result_pc_q;
    logic             result_q;
    logic             mispredict_q;

    brt_entry_t       head_s;
    brt_entry_t       entry_s;
    logic             full_s, empty_s;
    logic [OCC_W-1:0] occ_s;
    logic             issue_fire_s, exec_fire_s, mis_s;

    assign issue_fire_s = bus_if.issue_valid && bus_if.issue_ready;
    assign exec_fire_s  = bus_if.exec_valid && bus_if.exec_ready;
    assign mis_s        = exec_fire_s && brt_is_mispredict(head_s, bus_if.exec_taken);
    assign entry_s      = '{pc: bus_if.issue_pc, pred: bus_if.issue_pred};

    // a mispredict discards everything younger, including a same-cycle push
    branch_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (mis_s),
        .push_i      (issue_fire_s),
        .entry_i     (entry_s),
        .pop_i       (exec_fire_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .occupancy_o (occ_s)
    );

    // FSM next state and flush countdown
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            BRT_RUN: begin
                if (mis_s) begin
                    state_d     = BRT_FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d     = BRT_RUN;
                end
            end
            BRT_FLUSH: begin
                if (flush_cnt_q == CNT_W'(0)) begin
                    state_d = BRT_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = BRT_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // FSM state, flush counter and registered training outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BRT_RUN;
            flush_cnt_q    <= '0;
            result_valid_q <= 1'b0;
            result_pc_q    <= '0;
            result_q       <= 1'b0;
            mispredict_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            result_valid_q <= exec_fire_s;
            mispredict_q   <= mis_s;
            if (exec_fire_s) begin
                result_pc_q <= head_s.pc;
                result_q    <= bus_if.exec_taken;
            end
        end
    end

`ifdef BRT_PERF_COUNTERS_EN
    // training and mispredict event counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count  <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (result_valid_q) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict_q) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end
`endif

    assign bus_if.issue_ready  = (state_q == BRT_RUN) && !full_s;
    assign bus_if.exec_ready   = (state_q == BRT_RUN) && !empty_s;
    assign bus_if.result_valid = result_valid_q;
    assign bus_if.result_pc    = result_pc_q;
    assign bus_if.result       = result_q;
    assign bus_if.mispredict   = mispredict_q;
    assign bus_if.flush        = (state_q == BRT_FLUSH);
    assign bus_if.occupancy    = occ_s;

endmodule
